// File: rtl/regfile_bank_arb_pkg.sv
// Shared sizing defaults for the regfile bank arbiter slice.
// Latency: n/a (constants and elaboration-time helpers only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int ROW_DEF    = 16;
  localparam int WIDTH_DEF  = 256;
  localparam int NUM_RD_DEF = 4;
  localparam int NUM_WR_DEF = 2;

  // Index width for n entries; never below one bit so single-entry
  // configurations still have a legal (constant zero) index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_WIDTH_DEF = idx_width(ROW_DEF);

endpackage

// File: rtl/regfile_bank_arb_rr_arbiter.sv
// Circular priority picker: first eligible request at or after ptr_i.
// Latency: purely combinational.
// Backpressure: none; masked-out requests are simply never granted.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  req_mask_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  logic [N-1:0] eligible;
  int           idx;

  assign eligible = req_i & ~req_mask_i;

  // Walk N positions starting at the pointer; the first eligible one wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    idx       = 0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr_i) + off;
      if (idx >= N) idx = idx - N;
      if (!any_o && eligible[IW'(idx)]) begin
        any_o              = 1'b1;
        gnt_o[IW'(idx)]    = 1'b1;
        gnt_idx_o          = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_bank_arb.sv
// Shares one 2R/1W masked regfile bank among NUM_RD readers and NUM_WR writers, round-robin.
// Latency: read data registered, 1 cycle after grant; write lands in bank at the grant edge.
// Backpressure: ready is combinational from valid; a requester holds its request until granted.
module regfile_bank_arb
  import regfile_pkg::*;
#(
  parameter int NUM_RD    = NUM_RD_DEF,
  parameter int NUM_WR    = NUM_WR_DEF,
  parameter int ROW       = ROW_DEF,
  parameter int ROW_WIDTH = idx_width(ROW),
  parameter int WIDTH     = WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_RD-1:0]           rd_req_valid,
  output logic [NUM_RD-1:0]           rd_req_ready,
  input  logic [NUM_RD*ROW_WIDTH-1:0] rd_req_addr,
  output logic [NUM_RD-1:0]           rd_resp_valid,
  output logic [NUM_RD*WIDTH-1:0]     rd_resp_data,
  input  logic [NUM_WR-1:0]           wr_req_valid,
  output logic [NUM_WR-1:0]           wr_req_ready,
  input  logic [NUM_WR*ROW_WIDTH-1:0] wr_req_addr,
  input  logic [NUM_WR*WIDTH-1:0]     wr_req_mask,
  input  logic [NUM_WR*WIDTH-1:0]     wr_req_data,
  output logic [ROW_WIDTH-1:0]        bank_raddr1,
  output logic [ROW_WIDTH-1:0]        bank_raddr2,
  input  logic [WIDTH-1:0]            bank_rdata1,
  input  logic [WIDTH-1:0]            bank_rdata2,
  output logic                        bank_wen,
  output logic [ROW_WIDTH-1:0]        bank_waddr,
  output logic [WIDTH-1:0]            bank_wmask,
  output logic [WIDTH-1:0]            bank_wdata
);

  localparam int RPW = idx_width(NUM_RD);
  localparam int WPW = idx_width(NUM_WR);

  logic [RPW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [WPW-1:0]          wr_ptr_q, wr_ptr_d;

  logic [NUM_RD-1:0]       gnt_a, gnt_b;
  logic [RPW-1:0]          idx_a, idx_b, ptr_b;
  logic                    any_a, any_b;

  logic [NUM_WR-1:0]       wr_gnt;
  logic [WPW-1:0]          wr_idx;
  logic                    wr_any;

  logic [NUM_RD-1:0]       rd_resp_valid_q;
  logic [NUM_RD*WIDTH-1:0] rd_resp_data_q;

  // Port 1 reader: first valid at or after the read pointer.
  rr_arbiter #(.N(NUM_RD), .IW(RPW)) u_rd_arb_a (
    .req_i      (rd_req_valid),
    .ptr_i      (rd_ptr_q),
    .req_mask_i ({NUM_RD{1'b0}}),
    .gnt_o      (gnt_a),
    .gnt_idx_o  (idx_a),
    .any_o      (any_a)
  );

  // Port 2 reader: first valid strictly after A, with A itself excluded.
  rr_arbiter #(.N(NUM_RD), .IW(RPW)) u_rd_arb_b (
    .req_i      (rd_req_valid),
    .ptr_i      (ptr_b),
    .req_mask_i (gnt_a),
    .gnt_o      (gnt_b),
    .gnt_idx_o  (idx_b),
    .any_o      (any_b)
  );

  // Single write port arbiter.
  rr_arbiter #(.N(NUM_WR), .IW(WPW)) u_wr_arb (
    .req_i      (wr_req_valid),
    .ptr_i      (wr_ptr_q),
    .req_mask_i ({NUM_WR{1'b0}}),
    .gnt_o      (wr_gnt),
    .gnt_idx_o  (wr_idx),
    .any_o      (wr_any)
  );

  // Search start for port 2 is the slot after A; also the next pointer when only A is granted.
  always_comb begin
    ptr_b = (idx_a == RPW'(NUM_RD - 1)) ? '0 : idx_a + RPW'(1);
  end

  // Next pointers move just past the last granted requester; idle cycles hold them.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (any_b) begin
      rd_ptr_d = (idx_b == RPW'(NUM_RD - 1)) ? '0 : idx_b + RPW'(1);
    end else if (any_a) begin
      rd_ptr_d = ptr_b;
    end
    wr_ptr_d = wr_ptr_q;
    if (wr_any) begin
      wr_ptr_d = (wr_idx == WPW'(NUM_WR - 1)) ? '0 : wr_idx + WPW'(1);
    end
  end

  // Round-robin pointer state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Bank-facing address and write fields; idle ports drive zero.
  always_comb begin
    bank_raddr1 = '0;
    bank_raddr2 = '0;
    bank_wen    = 1'b0;
    bank_waddr  = '0;
    bank_wmask  = '0;
    bank_wdata  = '0;
    if (any_a) bank_raddr1 = rd_req_addr[int'(idx_a)*ROW_WIDTH +: ROW_WIDTH];
    if (any_b) bank_raddr2 = rd_req_addr[int'(idx_b)*ROW_WIDTH +: ROW_WIDTH];
    if (wr_any) begin
      bank_wen   = 1'b1;
      bank_waddr = wr_req_addr[int'(wr_idx)*ROW_WIDTH +: ROW_WIDTH];
      bank_wmask = wr_req_mask[int'(wr_idx)*WIDTH +: WIDTH];
      bank_wdata = wr_req_data[int'(wr_idx)*WIDTH +: WIDTH];
    end
  end

  // Capture combinational bank read data for the granted readers; others keep their last data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_resp_valid_q <= '0;
      rd_resp_data_q  <= '0;
    end else begin
      rd_resp_valid_q <= gnt_a | gnt_b;
      for (int i = 0; i < NUM_RD; i++) begin
        if (gnt_a[i]) begin
          rd_resp_data_q[i*WIDTH +: WIDTH] <= bank_rdata1;
        end else if (gnt_b[i]) begin
          rd_resp_data_q[i*WIDTH +: WIDTH] <= bank_rdata2;
        end
      end
    end
  end

  assign rd_req_ready  = gnt_a | gnt_b;
  assign wr_req_ready  = wr_gnt;
  assign rd_resp_valid = rd_resp_valid_q;
  assign rd_resp_data  = rd_resp_data_q;

endmodule

// File: tb/tb_regfile_bank_arb.sv
// Directed bench for regfile_bank_arb paired with a behavioural 16x256 masked regfile bank.
// Latency: checks read data one cycle after grant, writes visible the cycle after grant.
// Backpressure: exercises contention on both read ports and the write port.
module tb_regfile_bank_arb;

  localparam int NUM_RD = 4;
  localparam int NUM_WR = 2;
  localparam int ROW    = 16;
  localparam int RW     = 4;
  localparam int W      = 256;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_RD-1:0]     rd_req_valid;
  logic [NUM_RD-1:0]     rd_req_ready;
  logic [NUM_RD*RW-1:0]  rd_req_addr;
  logic [NUM_RD-1:0]     rd_resp_valid;
  logic [NUM_RD*W-1:0]   rd_resp_data;
  logic [NUM_WR-1:0]     wr_req_valid;
  logic [NUM_WR-1:0]     wr_req_ready;
  logic [NUM_WR*RW-1:0]  wr_req_addr;
  logic [NUM_WR*W-1:0]   wr_req_mask;
  logic [NUM_WR*W-1:0]   wr_req_data;
  logic [RW-1:0]         bank_raddr1;
  logic [RW-1:0]         bank_raddr2;
  logic [W-1:0]          bank_rdata1;
  logic [W-1:0]          bank_rdata2;
  logic                  bank_wen;
  logic [RW-1:0]         bank_waddr;
  logic [W-1:0]          bank_wmask;
  logic [W-1:0]          bank_wdata;

  logic [W-1:0]          bank_mem [ROW];

  int n_cmp;
  int n_err;

  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  regfile_bank_arb #(
    .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .ROW(ROW), .ROW_WIDTH(RW), .WIDTH(W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_data  (rd_resp_data),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_req_mask   (wr_req_mask),
    .wr_req_data   (wr_req_data),
    .bank_raddr1   (bank_raddr1),
    .bank_raddr2   (bank_raddr2),
    .bank_rdata1   (bank_rdata1),
    .bank_rdata2   (bank_rdata2),
    .bank_wen      (bank_wen),
    .bank_waddr    (bank_waddr),
    .bank_wmask    (bank_wmask),
    .bank_wdata    (bank_wdata)
  );

  // Behavioural bank: combinational reads, bit-masked write at the clock edge, no reset.
  always @(posedge clk) begin
    if (bank_wen)
      bank_mem[bank_waddr] <= (bank_mem[bank_waddr] & ~bank_wmask) | (bank_wdata & bank_wmask);
  end
  assign bank_rdata1 = bank_mem[bank_raddr1];
  assign bank_rdata2 = bank_mem[bank_raddr2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pat(input int r);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(r);
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int i, input logic v, input logic [RW-1:0] a);
    rd_req_valid[i]          = v;
    rd_req_addr[i*RW +: RW]  = a;
  endtask

  task automatic set_wr(input int i, input logic v, input logic [RW-1:0] a,
                        input logic [W-1:0] m, input logic [W-1:0] d);
    wr_req_valid[i]         = v;
    wr_req_addr[i*RW +: RW] = a;
    wr_req_mask[i*W +: W]   = m;
    wr_req_data[i*W +: W]   = d;
  endtask

  task automatic clear_all();
    rd_req_valid = '0;
    rd_req_addr  = '0;
    wr_req_valid = '0;
    wr_req_addr  = '0;
    wr_req_mask  = '0;
    wr_req_data  = '0;
  endtask

  task automatic preload(input logic [RW-1:0] row, input logic [W-1:0] d);
    set_wr(0, 1'b1, row, ONES, d);
    tick();
    set_wr(0, 1'b0, '0, ZERO, ZERO);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (rd_resp_valid !== 4'b0000) begin
      n_err++; $display("FAIL reset_resp_valid: got %b expected 0000", rd_resp_valid);
    end
    n_cmp++;
    if (rd_resp_data !== {NUM_RD*W{1'b0}}) begin
      n_err++; $display("FAIL reset_resp_data: got nonzero %h expected 0", rd_resp_data[W-1:0]);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (rd_req_ready !== 4'b0000) begin
        n_err++; $display("FAIL idle_rd_ready c%0d: got %b expected 0000", c, rd_req_ready);
      end
      n_cmp++;
      if (wr_req_ready !== 2'b00) begin
        n_err++; $display("FAIL idle_wr_ready c%0d: got %b expected 00", c, wr_req_ready);
      end
      n_cmp++;
      if (bank_wen !== 1'b0) begin
        n_err++; $display("FAIL idle_wen c%0d: got %b expected 0", c, bank_wen);
      end
      n_cmp++;
      if (rd_resp_valid !== 4'b0000) begin
        n_err++; $display("FAIL idle_resp_valid c%0d: got %b expected 0000", c, rd_resp_valid);
      end
    end
  endtask

  task automatic test_write_read();
    logic [W-1:0] got;
    set_wr(0, 1'b1, 4'd3, ONES, ONES);
    #1;
    n_cmp++;
    if (wr_req_ready !== 2'b01) begin
      n_err++; $display("FAIL wr_full_ready: got %b expected 01", wr_req_ready);
    end
    n_cmp++;
    if (bank_wen !== 1'b1 || bank_waddr !== 4'd3 || bank_wdata !== ONES) begin
      n_err++; $display("FAIL wr_full_bank: got wen %b addr %0d expected wen 1 addr 3", bank_wen, bank_waddr);
    end
    tick();
    set_wr(0, 1'b0, '0, ZERO, ZERO);
    set_rd(1, 1'b1, 4'd3);
    #1;
    n_cmp++;
    if (rd_req_ready !== 4'b0010) begin
      n_err++; $display("FAIL rd_single_ready: got %b expected 0010", rd_req_ready);
    end
    n_cmp++;
    if (bank_raddr1 !== 4'd3 || bank_raddr2 !== 4'd0) begin
      n_err++; $display("FAIL rd_single_addr: got %0d/%0d expected 3/0", bank_raddr1, bank_raddr2);
    end
    tick();
    set_rd(1, 1'b0, '0);
    got = rd_resp_data[1*W +: W];
    n_cmp++;
    if (rd_resp_valid !== 4'b0010) begin
      n_err++; $display("FAIL rd_single_valid: got %b expected 0010", rd_resp_valid);
    end
    n_cmp++;
    if (got !== ONES) begin
      n_err++; $display("FAIL rd_single_data: got %h expected all ones", got);
    end
    tick();
    n_cmp++;
    if (rd_resp_valid !== 4'b0000) begin
      n_err++; $display("FAIL rd_pulse_end: got %b expected 0000", rd_resp_valid);
    end
    // Partial write clears the low nibble of every byte.
    set_wr(0, 1'b1, 4'd3, {32{8'h0F}}, ZERO);
    tick();
    set_wr(0, 1'b0, '0, ZERO, ZERO);
    // All-zero mask is still granted but must not alter the row.
    set_wr(1, 1'b1, 4'd3, ZERO, ZERO);
    #1;
    n_cmp++;
    if (wr_req_ready !== 2'b10 || bank_wen !== 1'b1) begin
      n_err++; $display("FAIL wr_zero_mask: got ready %b wen %b expected 10/1", wr_req_ready, bank_wen);
    end
    tick();
    set_wr(1, 1'b0, '0, ZERO, ZERO);
    set_rd(1, 1'b1, 4'd3);
    tick();
    set_rd(1, 1'b0, '0);
    got = rd_resp_data[1*W +: W];
    n_cmp++;
    if (got !== {32{8'hF0}}) begin
      n_err++; $display("FAIL rd_partial_data: got %h expected f0 bytes", got);
    end
  endtask

  task automatic test_rd_round_robin();
    logic [W-1:0] got_lo, got_hi;
    logic [3:0]   exp_g;
    int           g0;
    for (int r = 8; r < 12; r++) preload(4'(r), pat(r));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NUM_RD; i++) set_rd(i, 1'b1, 4'(8 + i));
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_g = (c % 2 == 1) ? 4'b1100 : 4'b0011;
      g0    = (c % 2 == 1) ? 2 : 0;
      n_cmp++;
      if (rd_req_ready !== exp_g) begin
        n_err++; $display("FAIL rr_ready c%0d: got %b expected %b", c, rd_req_ready, exp_g);
      end
      tick();
      got_lo = rd_resp_data[g0*W +: W];
      got_hi = rd_resp_data[(g0+1)*W +: W];
      n_cmp++;
      if (rd_resp_valid !== exp_g) begin
        n_err++; $display("FAIL rr_valid c%0d: got %b expected %b", c, rd_resp_valid, exp_g);
      end
      n_cmp++;
      if (got_lo !== pat(8 + g0) || got_hi !== pat(9 + g0)) begin
        n_err++; $display("FAIL rr_data c%0d: got %h/%h expected %h/%h", c,
                          got_lo[31:0], got_hi[31:0], pat(8 + g0) & 32'hFFFF_FFFF, pat(9 + g0) & 32'hFFFF_FFFF);
      end
    end
    clear_all();
    // Move the pointer to 2, then requesters 3 and 0 must wrap: A=3 on port 1, B=0 on port 2.
    set_rd(1, 1'b1, 4'd9);
    tick();
    set_rd(1, 1'b0, '0);
    set_rd(0, 1'b1, 4'd8);
    set_rd(3, 1'b1, 4'd11);
    #1;
    n_cmp++;
    if (rd_req_ready !== 4'b1001 || bank_raddr1 !== 4'd11 || bank_raddr2 !== 4'd8) begin
      n_err++; $display("FAIL rr_wrap_grant: got %b %0d/%0d expected 1001 11/8", rd_req_ready, bank_raddr1, bank_raddr2);
    end
    tick();
    clear_all();
    got_lo = rd_resp_data[0*W +: W];
    got_hi = rd_resp_data[3*W +: W];
    n_cmp++;
    if (got_lo !== pat(8) || got_hi !== pat(11)) begin
      n_err++; $display("FAIL rr_wrap_data: got %h/%h expected c0de0008/c0de000b", got_lo[31:0], got_hi[31:0]);
    end
  endtask

  task automatic test_wr_round_robin();
    logic [W-1:0] got;
    logic [1:0]   exp_g;
    set_wr(0, 1'b1, 4'd6, ONES, {32{8'h11}});
    set_wr(1, 1'b1, 4'd6, ONES, {32{8'h22}});
    for (int c = 0; c < 4; c++) begin
      #1;
      exp_g = (c % 2 == 1) ? 2'b10 : 2'b01;
      n_cmp++;
      if (wr_req_ready !== exp_g) begin
        n_err++; $display("FAIL wr_rr_ready c%0d: got %b expected %b", c, wr_req_ready, exp_g);
      end
      n_cmp++;
      if (bank_wdata !== ((c % 2 == 1) ? {32{8'h22}} : {32{8'h11}})) begin
        n_err++; $display("FAIL wr_rr_data c%0d: got %h", c, bank_wdata[31:0]);
      end
      tick();
    end
    clear_all();
    set_rd(0, 1'b1, 4'd6);
    tick();
    set_rd(0, 1'b0, '0);
    got = rd_resp_data[0*W +: W];
    n_cmp++;
    if (got !== {32{8'h22}}) begin
      n_err++; $display("FAIL wr_rr_final: got %h expected 22 bytes", got[31:0]);
    end
  endtask

  task automatic test_rw_same_row();
    logic [W-1:0] got;
    preload(4'd5, {32{8'h55}});
    set_wr(0, 1'b1, 4'd5, ONES, {32{8'hAA}});
    set_rd(2, 1'b1, 4'd5);
    #1;
    n_cmp++;
    if (wr_req_ready !== 2'b01 || rd_req_ready !== 4'b0100) begin
      n_err++; $display("FAIL rw_grants: got wr %b rd %b expected 01/0100", wr_req_ready, rd_req_ready);
    end
    tick();
    set_wr(0, 1'b0, '0, ZERO, ZERO);
    got = rd_resp_data[2*W +: W];
    n_cmp++;
    if (rd_resp_valid !== 4'b0100 || got !== {32{8'h55}}) begin
      n_err++; $display("FAIL rw_old_data: got %b %h expected 0100 55 bytes", rd_resp_valid, got[31:0]);
    end
    tick();
    set_rd(2, 1'b0, '0);
    got = rd_resp_data[2*W +: W];
    n_cmp++;
    if (rd_resp_valid !== 4'b0100 || got !== {32{8'hAA}}) begin
      n_err++; $display("FAIL rw_new_data: got %b %h expected 0100 aa bytes", rd_resp_valid, got[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] got_lo, got_hi;
    set_rd(0, 1'b1, 4'd8);
    tick();
    set_rd(0, 1'b0, '0);
    n_cmp++;
    if (rd_resp_valid !== 4'b0001) begin
      n_err++; $display("FAIL mid_pre_valid: got %b expected 0001", rd_resp_valid);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_resp_valid !== 4'b0000) begin
      n_err++; $display("FAIL mid_async_valid: got %b expected 0000", rd_resp_valid);
    end
    tick();
    rst_n = 1'b1;
    set_rd(0, 1'b1, 4'd8);
    set_rd(3, 1'b1, 4'd11);
    set_wr(0, 1'b1, 4'd12, ZERO, ONES);
    set_wr(1, 1'b1, 4'd12, ZERO, ONES);
    #1;
    n_cmp++;
    if (rd_req_ready !== 4'b1001 || bank_raddr1 !== 4'd8 || bank_raddr2 !== 4'd11) begin
      n_err++; $display("FAIL mid_rd_ptr: got %b %0d/%0d expected 1001 8/11", rd_req_ready, bank_raddr1, bank_raddr2);
    end
    n_cmp++;
    if (wr_req_ready !== 2'b01) begin
      n_err++; $display("FAIL mid_wr_ptr: got %b expected 01", wr_req_ready);
    end
    tick();
    clear_all();
    got_lo = rd_resp_data[0*W +: W];
    got_hi = rd_resp_data[3*W +: W];
    n_cmp++;
    if (got_lo !== pat(8) || got_hi !== pat(11)) begin
      n_err++; $display("FAIL mid_bank_kept: got %h/%h expected c0de0008/c0de000b", got_lo[31:0], got_hi[31:0]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_all();
    test_reset();
    test_write_read();
    test_rd_round_robin();
    test_wr_round_robin();
    test_rw_same_row();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
